// File: rtl/mem_rd_responder.sv
// Memory read responder: accepts read requests against a local backing memory
// and returns the data through a 2-entry in-order response FIFO.
module mem_rd_responder #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [1:0]    outstanding
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  logic [DW-1:0] mem_q [2**AW];

  logic [DW-1:0] fifo_q [2];
  logic [DW-1:0] fifo_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  state_e        state_q, state_d;

  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;

  logic          push, pop;
  logic [DW-1:0] cap_data;

  // Backing memory is not reset; writes are honoured even during reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_comb begin
    push     = req_valid && req_ready_q;
    pop      = rsp_valid_q && rsp_ready;
    cap_data = (wr_en && (wr_addr == req_addr)) ? wr_data : mem_q[req_addr];

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;

    if (push) begin
      fifo_d[wr_ptr_q] = cap_data;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase

    // Outputs are registered, so derive them from the post-edge state and FIFO.
    req_ready_d = (state_d != FULL);
    rsp_valid_d = (state_d != EMPTY);
    rsp_data_d  = rsp_valid_d ? fifo_d[rd_ptr_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      fifo_q      <= fifo_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign outstanding = state_q;

endmodule

// File: doc/mem_rd_responder.md
MEM_RD_RESPONDER -- requirements
Module: mem_rd_responder

Interface
REQ-001 Parameter AW, default 4, memory address width in bits.
REQ-002 Parameter DW, default 8, memory data width in bits.
REQ-003 Port clk, input, 1, clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1, reset; synchronous, active-high.
REQ-005 Port req_valid, input, 1, read request from the initiator is present.
REQ-006 Port req_ready, output, 1, responder can accept a read request this cycle.
REQ-007 Port req_addr, input, AW, read address; sampled when req_valid && req_ready.
REQ-008 Port rsp_valid, output, 1, head response entry is valid.
REQ-009 Port rsp_ready, input, 1, initiator consumes the response this cycle.
REQ-010 Port rsp_data, output, DW, read data of the head response entry.
REQ-011 Port wr_en, input, 1, write strobe for backing memory.
REQ-012 Port wr_addr, input, AW, write address.
REQ-013 Port wr_data, input, DW, write data.
REQ-014 Port outstanding, output, 2, number of queued responses (0..2).

Function
REQ-015 Backing memory: 2**AW entries x DW bits; written on the clk edge when wr_en=1; never cleared by reset.
REQ-016 A request is accepted on a clk edge when req_valid=1 and req_ready=1; otherwise req_addr is ignored.
REQ-017 Read data for an accepted request is mem[req_addr] as seen in the acceptance cycle, except as given in REQ-018.
REQ-018 Same-cycle write/read bypass: if wr_en=1 and wr_addr==req_addr in the acceptance cycle, the captured data is wr_data.
REQ-019 Captured data is pushed into a 2-entry in-order response FIFO on the acceptance edge.
REQ-020 Latency: a request accepted at edge N gives rsp_valid=1 in the cycle after edge N, provided no older entry is pending.
REQ-021 State machine on outstanding: EMPTY(0), ONE(1), FULL(2).
REQ-022 Transitions: push only = +1; pop only = -1; push and pop together = unchanged; neither = unchanged.
REQ-023 Pop occurs on an edge with rsp_valid=1 and rsp_ready=1.
REQ-024 req_ready=1 iff outstanding<2; there is no same-cycle pass-through when FULL, even if rsp_ready=1.
REQ-025 rsp_valid=1 iff outstanding>0.
REQ-026 rsp_data equals the head entry when rsp_valid=1, and 0 when rsp_valid=0.
REQ-027 While rsp_valid=1 and rsp_ready=0, rsp_data and rsp_valid hold stable.
REQ-028 Responses are returned in acceptance order; no entry is dropped or duplicated.
REQ-029 A write to an address already captured in the FIFO does not alter the queued data.
REQ-030 rsp_ready while rsp_valid=0 has no effect.
REQ-031 FIFO pointers are 1 bit each and wrap modulo 2.

Reset
REQ-032 When rst=1 at an edge: outstanding=0, FIFO pointers=0, rsp_valid=0, rsp_data=0, req_ready=1 from the next cycle.
REQ-033 Reset during operation flushes all queued responses; memory contents and any write in the reset cycle are retained.
REQ-034 Requests presented in a reset cycle are not accepted.

Verification
REQ-035 Write mem[3]=0xA5; read addr 3 with rsp_ready=1 -> rsp_valid=1 the next cycle with rsp_data=0xA5; outstanding returns to 0.
REQ-036 rsp_ready=0; issue reads to addr 1 (0x11), 2 (0x22), 3 -> first two accepted, req_ready=0 at outstanding=2 and the third is not accepted; raise rsp_ready -> 0x11 then 0x22 in order.
REQ-037 Same cycle wr_en=1, wr_addr=5, wr_data=0x5C and read addr 5 (old value 0x00) -> response data 0x5C.
REQ-038 Queue a read of addr 7 (0x70), then write 0xFF to addr 7 before the pop -> rsp_data=0x70.
REQ-039 outstanding=1, simultaneous pop and new accept -> outstanding stays 1, with the new data at the head the next cycle.
REQ-040 outstanding=2, assert rst -> next cycle rsp_valid=0, rsp_data=0, outstanding=0, req_ready=1; a subsequent read of a prewritten address returns the pre-reset memory value.
